// File: rtl/serial_if_pkg.sv
// Shared widths and word types for the serial interface datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_if_pkg;

  localparam int DEFAULT_CMD_W = 8;   // write-phase tclk count
  localparam int DEFAULT_RD_W  = 9;   // read-phase tclk count
  localparam int FRAME_LEN     = 40;  // FSM cycles per complete frame

  typedef logic [DEFAULT_CMD_W-1:0] cmd_t;
  typedef logic [DEFAULT_RD_W-1:0]  rsp_t;

endpackage

// File: rtl/serial_shift_datapath_edge_detect.sv
// Registers a level and flags its rising and falling transitions.
// Latency: rise/fall are combinational against the one-cycle-old copy.
// Backpressure: none; every transition produces exactly one pulse.
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic sig_q;

  // One-cycle history of the watched level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig;
    end
  end

  assign rise = sig & ~sig_q;
  assign fall = ~sig & sig_q;

endmodule

// File: rtl/serial_shift_datapath.sv
// Serializes a queued command MSB-first and deserializes the response per frame.
// Latency: rd_valid one clock after trst is sampled low; cmd_ready drops one clock after accept.
// Backpressure: single-entry holding register; cmd_ready low until the next frame start empties it.
module serial_shift_datapath
  import serial_if_pkg::*;
#(
  parameter int CMD_W = DEFAULT_CMD_W,
  parameter int RD_W  = DEFAULT_RD_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tclk,
  input  logic            trst,
  input  logic            dq_en,
  input  logic            sr_en,
  input  logic [CMD_W-1:0] cmd_data,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            dq_in,
  output logic            dq_out,
  output logic            dq_oe,
  output logic [RD_W-1:0] rd_data,
  output logic            rd_valid,
  output logic            frame_err
);

  // Counters must reach one past the nominal count so overruns are visible.
  localparam int TXC_W = $clog2(CMD_W + 2);
  localparam int RXC_W = $clog2(RD_W + 2);

  localparam logic [TXC_W-1:0] TX_FULL = TXC_W'(CMD_W);
  localparam logic [TXC_W-1:0] TX_SAT  = TXC_W'(CMD_W + 1);
  localparam logic [RXC_W-1:0] RX_FULL = RXC_W'(RD_W);
  localparam logic [RXC_W-1:0] RX_SAT  = RXC_W'(RD_W + 1);

  logic             frame_start;
  logic             frame_end;
  logic             accept;
  logic             tx_step;
  logic             rx_step;

  logic             hold_full;
  logic [CMD_W-1:0] hold_data;
  logic [CMD_W-1:0] tx_shift;
  logic [TXC_W-1:0] tx_cnt;
  logic [RD_W-1:0]  rx_shift;
  logic [RXC_W-1:0] rx_cnt;

  edge_detect u_trst_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .sig   (trst),
    .rise  (frame_start),
    .fall  (frame_end)
  );

  assign cmd_ready = ~hold_full;
  assign accept    = cmd_valid & cmd_ready;

  // Advance after the tclk-high half so each bit spans its low and high cycles.
  assign tx_step = dq_en & tclk & ~sr_en;
  // Read samples only inside a frame and only when we are not driving the line.
  assign rx_step = sr_en & ~dq_en & trst;

  assign dq_out = tx_shift[CMD_W-1];
  assign dq_oe  = dq_en;

  // Holding register: a word accepted on the frame-start cycle waits for the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else begin
      if (accept) begin
        hold_data <= cmd_data;
      end
      if (frame_start) begin
        hold_full <= accept;
      end else if (accept) begin
        hold_full <= 1'b1;
      end
    end
  end

  // Per-frame shift registers and bit counters, restarted on every frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift <= '0;
      tx_cnt   <= '0;
      rx_shift <= '0;
      rx_cnt   <= '0;
    end else if (frame_start) begin
      tx_shift <= hold_full ? hold_data : '0;
      tx_cnt   <= '0;
      rx_shift <= '0;
      rx_cnt   <= '0;
    end else begin
      if (tx_step) begin
        tx_shift <= {tx_shift[CMD_W-2:0], 1'b0};
        if (tx_cnt != TX_SAT) begin
          tx_cnt <= tx_cnt + 1'b1;
        end
      end
      if (rx_step) begin
        rx_shift <= {rx_shift[RD_W-2:0], dq_in};
        if (rx_cnt != RX_SAT) begin
          rx_cnt <= rx_cnt + 1'b1;
        end
      end
    end
  end

  // Frame-end publication: response word plus single-cycle valid and error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rd_valid  <= frame_end;
      frame_err <= frame_end & ((tx_cnt != TX_FULL) | (rx_cnt != RX_FULL));
      if (frame_end) begin
        rd_data <= rx_shift;
      end
    end
  end

endmodule

// File: tb/tb_serial_shift_datapath.sv
// Scoreboard bench: stimulus pushes expected serial bits and responses, a monitor pops on dq_oe/rd_valid.
// Latency: checks tolerate the documented one-clock publication delay.
// Backpressure: cmd_ready sampled directly around accept and frame start.
module tb_serial_shift_datapath;
  import serial_if_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic tclk, trst, dq_en, sr_en;
  cmd_t cmd_data;
  logic cmd_valid, cmd_ready;
  logic dq_in, dq_out, dq_oe;
  rsp_t rd_data;
  logic rd_valid, frame_err;

  int total = 0;
  int bad   = 0;

  bit          dq_q[$];
  logic [9:0]  rsp_q[$];   // {frame_err, rd_data}

  serial_shift_datapath dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tclk      (tclk),
    .trst      (trst),
    .dq_en     (dq_en),
    .sr_en     (sr_en),
    .cmd_data  (cmd_data),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .dq_in     (dq_in),
    .dq_out    (dq_out),
    .dq_oe     (dq_oe),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every driven bit and every published response is matched against the queues.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (dq_oe) begin
        if (dq_q.size() == 0) check("dq_oe_unexpected", 1, 0);
        else check("dq_out_bit", {31'd0, dq_out}, {31'd0, dq_q.pop_front()});
      end
      if (rd_valid) begin
        if (rsp_q.size() == 0) check("rd_valid_unexpected", 1, 0);
        else check("rsp_word", {22'd0, frame_err, rd_data}, {22'd0, rsp_q.pop_front()});
      end else if (frame_err) begin
        check("frame_err_without_valid", 1, 0);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  task automatic offer(input cmd_t w);
    cmd_valid = 1'b1;
    cmd_data  = w;
    step();
    cmd_valid = 1'b0;
    check("cmd_ready_after_accept", {31'd0, cmd_ready}, 32'd0);
  endtask

  task automatic write_bits(input int nw, input cmd_t tx_exp);
    cmd_t w = tx_exp;
    for (int i = 0; i < nw; i++) begin
      dq_q.push_back(w[7-i]);   // low cycle
      dq_q.push_back(w[7-i]);   // high cycle
    end
    for (int i = 0; i < nw; i++) begin
      dq_en = 1'b1; tclk = 1'b0; sr_en = 1'b1; step();
      tclk = 1'b1; sr_en = 1'b0; step();
    end
    dq_en = 1'b0;
    check("dq_bits_consumed", dq_q.size(), 0);
  endtask

  task automatic read_bits(input int nr, input rsp_t rsp);
    for (int j = 0; j < nr; j++) begin
      tclk = 1'b0; sr_en = 1'b1; dq_in = rsp[8-j]; step();
      tclk = 1'b1; sr_en = 1'b0; step();
    end
    tclk = 1'b0;
  endtask

  task automatic run_frame(input int nw, input cmd_t tx_exp, input rsp_t rsp,
                           input bit acc, input cmd_t new_cmd);
    trst = 1'b1;
    cmd_valid = acc;
    cmd_data  = new_cmd;
    step();
    cmd_valid = 1'b0;
    check("cmd_ready_after_start", {31'd0, cmd_ready}, acc ? 32'd0 : 32'd1);
    write_bits(nw, tx_exp);
    read_bits(9, rsp);
    rsp_q.push_back({(nw != 8), rsp});
    trst = 1'b0;
    step();
    repeat (3) step();
    check("rsp_consumed", rsp_q.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    tclk = 1'b0; trst = 1'b0; dq_en = 1'b0; sr_en = 1'b0;
    cmd_data = '0; cmd_valid = 1'b0; dq_in = 1'b0;
    #12;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 1);
    check("rst_dq_out",    {31'd0, dq_out},    0);
    check("rst_dq_oe",     {31'd0, dq_oe},     0);
    check("rst_rd_data",   {23'd0, rd_data},   0);
    check("rst_rd_valid",  {31'd0, rd_valid},  0);
    check("rst_frame_err", {31'd0, frame_err}, 0);
    step();
    rst_n = 1'b1;
    repeat (2) step();

    // Queued A5, response 1B3.
    offer(8'hA5);
    step();
    check("cmd_ready_held_low", {31'd0, cmd_ready}, 0);
    run_frame(8, 8'hA5, 9'h1B3, 1'b0, 8'h00);
    check("rd_data_hold_1b3", {23'd0, rd_data}, 32'h1B3);

    // Idle frame: zeros out, response still published.
    run_frame(8, 8'h00, 9'h0F0, 1'b0, 8'h00);
    check("idle_cmd_ready", {31'd0, cmd_ready}, 1);

    // Accept on the frame-start cycle goes to the following frame.
    run_frame(8, 8'h00, 9'h055, 1'b1, 8'h3C);
    run_frame(8, 8'h3C, 9'h1AA, 1'b0, 8'h00);

    // Strobes outside a frame must not disturb anything.
    sr_en = 1'b1; dq_in = 1'b1; step(); sr_en = 1'b0; step();

    // Truncated write phase.
    offer(8'hC3);
    run_frame(7, 8'hC3, 9'h101, 1'b0, 8'h00);

    // Reset mid read phase.
    trst = 1'b1; step();
    write_bits(8, 8'h00);
    read_bits(4, 9'h1FF);
    offer(8'h99);
    rst_n = 1'b0;
    #1;
    check("mid_rst_cmd_ready", {31'd0, cmd_ready}, 1);
    check("mid_rst_dq_out",    {31'd0, dq_out},    0);
    check("mid_rst_dq_oe",     {31'd0, dq_oe},     0);
    check("mid_rst_rd_data",   {23'd0, rd_data},   0);
    check("mid_rst_rd_valid",  {31'd0, rd_valid},  0);
    check("mid_rst_frame_err", {31'd0, frame_err}, 0);
    trst = 1'b0; tclk = 1'b0; sr_en = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) step();
    check("mid_rst_no_rsp", rsp_q.size(), 0);
    run_frame(8, 8'h00, 9'h0C7, 1'b0, 8'h00);

    check("final_dq_queue", dq_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_shift_datapath.md
# serial_shift_datapath

Bit-level datapath downstream of the serial interface control FSM. It consumes the FSM's `tclk`/`trst`/`dq_en`/`sr_en` strobes. It serializes a queued command onto the bidirectional data line during the write phase and deserializes the target's response during the read phase. At frame end it presents the response as a parallel word with a one-cycle valid pulse.

## Interface
- `CMD_W`, default 8: command bits per frame, equal to the FSM's write-clock count.
- `RD_W`, default 9: response bits per frame, equal to the FSM's read-clock count.
- `clk` input 1: system clock, same clock as the control FSM.
- `rst_n` input 1: reset, asynchronous and active-low.
- `tclk` input 1: serial clock from the FSM.
- `trst` input 1: frame enable from the FSM; high for the whole frame.
- `dq_en` input 1: write-phase tristate enable from the FSM.
- `sr_en` input 1: shift enable from the FSM; high during tclk-low cycles.
- `cmd_data` input CMD_W: command word to send.
- `cmd_valid` input 1: command offer.
- `cmd_ready` output 1: holding register empty.
- `dq_in` input 1: sampled serial data line.
- `dq_out` output 1: serial data to drive.
- `dq_oe` output 1: pad output enable.
- `rd_data` output RD_W: last completed response.
- `rd_valid` output 1: one-cycle pulse when `rd_data` updates.
- `frame_err` output 1: one-cycle pulse, coincident with `rd_valid`, when the bit counts were wrong.

## Operation
- **Command holding register.**
  - Depth 1, plus `hold_full` flag.
  - `cmd_ready = !hold_full`.
  - Accept on `cmd_valid && cmd_ready`.
- **Frame start** is `trst` rising, detected against a registered copy `trst_q`. On frame start:
  - `tx_shift <= hold_full ? hold_data : 0`.
  - `hold_full` is cleared.
  - `tx_cnt`, `rx_cnt` and `rx_shift` are cleared.
- **Simultaneous accept and frame start.** The accepted word lands in the holding register for the next frame. There is no bypass.
- **Transmit.**
  - `dq_out = tx_shift[CMD_W-1]`, MSB first.
  - `dq_oe = dq_en`, combinational.
  - `tx_shift` shifts left, filling with 0, at the end of each cycle with `dq_en && tclk && !sr_en`. This keeps each bit stable across its low and high tclk cycles.
  - `tx_cnt` increments per shift and saturates at CMD_W+1.
- **Receive.**
  - On each cycle with `sr_en && !dq_en && trst`: `rx_shift <= {rx_shift[RD_W-2:0], dq_in}`.
  - `rx_cnt` increments per sample and saturates at RD_W+1.
- **Frame end** is `trst` falling. On frame end:
  - `rd_data <= rx_shift`.
  - `rd_valid` pulses.
  - `frame_err` pulses if `tx_cnt != CMD_W || rx_cnt != RD_W`.
- **Idle frame** (holding register empty at frame start): zeros are transmitted, and `rd_valid` still pulses.
- **Strobes outside a frame** (`sr_en` while `trst==0`): ignored, with no shift and no count.

## Timing
- **Reset values:**
  - `cmd_ready=1`, `dq_out=0`, `dq_oe=0` (follows `dq_en`), `rd_data=0`, `rd_valid=0`, `frame_err=0`.
  - `trst_q=0`, all shift registers and counters 0.
- **Latency:**
  - `rd_valid` asserts the cycle after the `trst` high→low transition is sampled, i.e. one clock after the FSM enters its end-of-frame state.
  - `cmd_ready` deasserts the cycle after acceptance. It reasserts the cycle after frame start.
- **Read samples:** `dq_in` is sampled on the clock edge ending each tclk-low read cycle. The target therefore must drive the line by the falling tclk.
- **Reset mid-frame:** the asynchronous clear drops any partial frame. No `rd_valid` is produced for it. The next `trst` rising edge starts a clean frame.
- **Consecutive frames:**
  - `trst` low for ≥1 cycle between frames is required. This is guaranteed by the FSM's end-of-frame and load states.
  - Back-to-back edges are each processed.

## Structure
- Shared package `serial_if_pkg`:
  - `CMD_W`, `RD_W` defaults.
  - `FRAME_LEN = 40`.
  - typedefs `cmd_t`, `rsp_t`.
- One sub-module, `edge_detect`, which registers `trst` and outputs the `rise`/`fall` pulses.
- Everything else lives in `serial_shift_datapath`.

## Test plan
- Offer `cmd_data=8'hA5` before frame start, then run one frame through the FSM → `dq_out` sequence is 1,0,1,0,0,1,0,1 across the 8 write low/high pairs. `dq_oe` is high only in the write phase. `cmd_ready` is low from acceptance until frame start.
- Drive `dq_in` with 9'h1B3, MSB first, in the read phase → `rd_data=9'h1B3` with a single-cycle `rd_valid`, and `frame_err=0`.
- No command queued → `dq_out=0` for all write bits, `rd_valid` still pulses, `cmd_ready` stays 1.
- `cmd_valid` asserted in the same cycle as `trst` rises, holding register empty → the frame transmits 0, and the next frame transmits the new word.
- Truncated frame: 7 write strobes, 9 read strobes → `frame_err=1` coincident with `rd_valid`.
- Assert `rst_n=0` mid read phase → all outputs return to reset values immediately. No `rd_valid` for that frame. The next full frame completes normally.
